cim_job_scheduler: RTL and testbench
====================================

// Module: cim_job_scheduler
// PURPOSE
//  Multi-channel successor to the single-job CIM controller. AHB slave register file that stages
//  GEMM descriptors, queues them in a QDEPTH FIFO and dispatches them to NUM_CH MAC channels.
//  Adds per-channel watchdog, flush, sticky W1C interrupts and a completion counter.
//  Sits between the AHB fabric and the NUM_CH cim_mac_array instances.
// PARAMETERS
//  NUM_CH   4      number of MAC channels (1..8)
//  QDEPTH   8      descriptor FIFO depth (power of 2, >=2)
//  DIM_W    16     width of dim_m/n/k fields
//  ADDR_W   32     AHB address width and buffer-address field width
//  TO_W     24     watchdog counter width
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous reset, active-high
//  haddr        in   ADDR_W     AHB address
//  hwdata       in   32         AHB write data (data phase)
//  hrdata       out  32         AHB read data (data phase)
//  hwrite/hsel  in   1/1        AHB write flag / slave select
//  htrans       in   2          AHB transfer type
//  hsize        in   3          AHB size (only 32-bit accesses supported; value ignored)
//  hready/hresp out  1/1        AHB ready (always 1) / response (always 0, OKAY)
//  job_m/n/k    out  DIM_W      dimensions of the job being dispatched
//  job_in/w/out out  ADDR_W     input, weight and output buffer addresses of that job
//  ch_start     out  NUM_CH     one-hot, 1-cycle dispatch pulse; job_* are valid in the same cycle
//  ch_done      in   NUM_CH     per-channel completion pulse
//  ch_abort     out  NUM_CH     1-cycle abort pulse (timeout or flush)
//  trigger_in   in   1          reflex hardware trigger
//  irq          out  1          level interrupt
// BEHAVIOUR
//  Reset: hrdata=0, hready=1, hresp=0, ch_start=0, ch_abort=0, irq=0, job_*=0. FIFO empty.
//   All channels idle. All registers 0.
//  AHB: address phase is captured when hsel&htrans[1]&hready. The access completes in the next
//   cycle (zero wait). hrdata is combinational from the captured address. Unmapped reads return 0.
//   Unmapped writes are ignored.
//  Register map:
//   00 CTRL     [0] EN, [1] FLUSH (self-clearing), [2] IRQ_EN, [3] TRIG_EN
//   04 STATUS   RO: [NUM_CH-1:0] busy, [15:8] fifo count, [16] full, [17] empty
//   08/0C/10    DIM_M/N/K staging
//   14/18/1C    IN/W/OUT address staging
//   20 PUSH     any write enqueues the staged descriptor
//   24 IRQ_STAT W1C: [0] DONE, [1] DRAINED, [2] OVF, [3] TIMEOUT
//   28 DONE_CNT RO, wraps at 2^32
//   2C TIMEOUT  cycle limit; 0 disables the watchdog
//  Push: an AHB PUSH write, or a trigger_in rising edge while TRIG_EN=1. Both in the same cycle
//   produce a single entry. A push while full is dropped and sets OVF, except when a pop occurs
//   in the same cycle, in which case the push is accepted.
//  Dispatch: at most one per cycle, when EN=1, the FIFO is non-empty and some channel is idle.
//   The round-robin search starts at (last granted channel + 1) mod NUM_CH.
//   Dispatch pops the FIFO, pulses ch_start[i] and marks channel i busy.
//   Latency: a push in cycle t makes ch_start possible at t+1 at the earliest.
//  Completion: ch_done[i] while busy sets channel i idle, adds popcount(valid dones) to DONE_CNT
//   and sets DONE. ch_done on an idle channel is ignored. Done and dispatch to the same channel
//   in one cycle are legal, and the channel ends busy.
//  Watchdog: each busy channel counts cycles from dispatch. When the count equals TIMEOUT
//   (TIMEOUT!=0): pulse ch_abort[i], set the channel idle, set TIMEOUT status, no DONE_CNT
//   increment. If ch_done arrives in the same cycle, done wins.
//  DRAINED sets on the cycle the FIFO is empty and all channels go idle after having been non-idle.
//  FLUSH: in the cycle after the write, empty the FIFO, pulse ch_abort on every busy channel and
//   set all channels idle. No dispatch in that cycle. DONE_CNT is preserved.
//  IRQ_STAT: if a set and a W1C clear hit the same bit in the same cycle, the set wins.
//   irq = IRQ_EN & |IRQ_STAT (registered, 1-cycle lag).
//  EN=0 halts dispatch only. Busy channels continue and complete normally.
// STRUCTURE
//  Package cim_sched_pkg: register offsets, CTRL/IRQ bit indices, desc_t packed struct
//   {m,n,k,in,w,out}.
//  Sub-module cim_desc_fifo: synchronous FIFO of desc_t with push/pop/flush/count/full/empty.
//   The arbiter and watchdogs stay in the top module.
// TESTING
//  1. Stage M=4,N=4,K=8, PUSH, EN=1 -> ch_start=0001 one cycle later with job_m=4.
//     ch_done[0] -> DONE_CNT=1, DONE and DRAINED set, irq=1 if IRQ_EN.
//  2. Push 6 jobs, NUM_CH=4, no dones -> ch_start sequence 0001,0010,0100,1000.
//     STATUS count=2, busy=1111.
//  3. Push QDEPTH+1 jobs with EN=0 -> count=8, full=1, OVF=1.
//     W1C 0x4 to IRQ_STAT clears OVF. DONE_CNT=0.
//  4. TIMEOUT=10, dispatch, no done -> ch_abort[0] exactly 10 cycles after ch_start.
//     TIMEOUT status bit set, DONE_CNT unchanged.
//  5. Queue 3 jobs and 2 busy channels, write FLUSH -> ch_abort=0011, count=0, empty=1.
//     No ch_start in the flush cycle.
//  6. TRIG_EN=1 with trigger_in and PUSH in the same cycle -> count increments by exactly 1.
//     rst asserted mid-job -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/cim_job_scheduler_pkg.sv
// Shared definitions for the CIM job scheduler: register map, CTRL/IRQ bit positions
// and the GEMM descriptor that flows through the dispatch FIFO.
package cim_sched_pkg;

   localparam int DESC_DIM_W  = 16;
   localparam int DESC_ADDR_W = 32;

   localparam logic [7:0] REG_CTRL     = 8'h00;
   localparam logic [7:0] REG_STATUS   = 8'h04;
   localparam logic [7:0] REG_DIM_M    = 8'h08;
   localparam logic [7:0] REG_DIM_N    = 8'h0C;
   localparam logic [7:0] REG_DIM_K    = 8'h10;
   localparam logic [7:0] REG_IN       = 8'h14;
   localparam logic [7:0] REG_W        = 8'h18;
   localparam logic [7:0] REG_OUT      = 8'h1C;
   localparam logic [7:0] REG_PUSH     = 8'h20;
   localparam logic [7:0] REG_IRQ      = 8'h24;
   localparam logic [7:0] REG_DONE_CNT = 8'h28;
   localparam logic [7:0] REG_TIMEOUT  = 8'h2C;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_FLUSH   = 1;
   localparam int CTRL_IRQ_EN  = 2;
   localparam int CTRL_TRIG_EN = 3;

   localparam int IRQ_DONE    = 0;
   localparam int IRQ_DRAINED = 1;
   localparam int IRQ_OVF     = 2;
   localparam int IRQ_TIMEOUT = 3;

   typedef struct packed {
      logic [DESC_DIM_W-1:0]  m;
      logic [DESC_DIM_W-1:0]  n;
      logic [DESC_DIM_W-1:0]  k;
      logic [DESC_ADDR_W-1:0] in_addr;
      logic [DESC_ADDR_W-1:0] w_addr;
      logic [DESC_ADDR_W-1:0] out_addr;
   } desc_t;

endpackage

// File: rtl/cim_desc_fifo.sv
// Synchronous descriptor FIFO. A push while full is accepted only if a pop frees a slot
// in the same cycle; flush empties it and overrides any push/pop.
module cim_desc_fifo
   import cim_sched_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  desc_t       din,
   output desc_t       dout,
   output logic [AW:0] count,
   output logic        full,
   output logic        empty
);
   desc_t         mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop & ~empty & ~flush;
      do_push  = push & (~full | do_pop) & ~flush;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/cim_job_scheduler.sv
// AHB register front-end, round-robin dispatcher, per-channel watchdogs and sticky
// interrupts for NUM_CH MAC channels fed from a descriptor FIFO.
module cim_job_scheduler
   import cim_sched_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int QDEPTH = 8,
   parameter int DIM_W  = DESC_DIM_W,
   parameter int ADDR_W = DESC_ADDR_W,
   parameter int TO_W   = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [31:0]       hwdata,
   output logic [31:0]       hrdata,
   input  logic              hwrite,
   input  logic              hsel,
   input  logic [1:0]        htrans,
   input  logic [2:0]        hsize,
   output logic              hready,
   output logic              hresp,
   output logic [DIM_W-1:0]  job_m,
   output logic [DIM_W-1:0]  job_n,
   output logic [DIM_W-1:0]  job_k,
   output logic [ADDR_W-1:0] job_in,
   output logic [ADDR_W-1:0] job_w,
   output logic [ADDR_W-1:0] job_out,
   output logic [NUM_CH-1:0] ch_start,
   input  logic [NUM_CH-1:0] ch_done,
   output logic [NUM_CH-1:0] ch_abort,
   input  logic              trigger_in,
   output logic              irq
);
   localparam int CNT_W = $clog2(QDEPTH) + 1;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                         ap_valid_q, ap_valid_d, ap_write_q, ap_write_d;
   logic [7:0]                   ap_addr_q, ap_addr_d;
   logic                         en_q, en_d, flush_q, flush_d, irq_en_q, irq_en_d;
   logic                         trig_en_q, trig_en_d, trig_prev_q, trig_prev_d, irq_q, irq_d;
   desc_t                        stage_q, stage_d;
   logic [3:0]                   irq_stat_q, irq_stat_d;
   logic [31:0]                  done_cnt_q, done_cnt_d;
   logic [TO_W-1:0]              timeout_q, timeout_d;
   logic [NUM_CH-1:0]            busy_q, busy_d;
   logic [NUM_CH-1:0][TO_W-1:0]  wd_cnt_q, wd_cnt_d;
   logic [CH_W-1:0]              last_q, last_d;

   logic              wr_act, rd_act, push_req, dispatch, found, drained, ovf;
   logic [NUM_CH-1:0] done_v, to_hit, free, start;
   logic [CH_W-1:0]   grant;
   logic [3:0]        irq_clr;
   int                idx;
   desc_t             fifo_head, job_desc;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full, fifo_empty;
   logic              unused_sink;

   assign unused_sink = ^{haddr, hsize, htrans[0]};
   assign hready = 1'b1;
   assign hresp  = 1'b0;
   assign irq    = irq_q;

   cim_desc_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (dispatch),
      .flush (flush_q),
      .din   (stage_q),
      .dout  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      wr_act = ap_valid_q & ap_write_q;
      rd_act = ap_valid_q & ~ap_write_q;
      push_req = (wr_act && ap_addr_q == REG_PUSH) | (trig_en_q & trigger_in & ~trig_prev_q);

      // A flush pre-empts completions: every busy channel is aborted instead.
      done_v = ch_done & busy_q & {NUM_CH{~flush_q}};
      for (int i = 0; i < NUM_CH; i++)
         to_hit[i] = busy_q[i] && timeout_q != '0 && wd_cnt_q[i] == timeout_q
                     && !ch_done[i] && !flush_q;

      // A channel completing this cycle may take the next job immediately.
      free  = ~busy_q | done_v;
      found = 1'b0;
      grant = '0;
      idx   = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = (int'(last_q) + k) % NUM_CH;
         if (!found && free[idx]) begin
            found = 1'b1;
            grant = CH_W'(idx);
         end
      end
      dispatch = en_q & ~flush_q & ~fifo_empty & found;
      start    = dispatch ? (NUM_CH'(1) << grant) : '0;
      last_d   = dispatch ? grant : last_q;
      job_desc = dispatch ? fifo_head : '0;

      busy_d = flush_q ? '0 : ((busy_q & ~done_v & ~to_hit) | start);
      for (int i = 0; i < NUM_CH; i++)
         wd_cnt_d[i] = start[i] ? TO_W'(1) : (busy_q[i] ? wd_cnt_q[i] + TO_W'(1) : wd_cnt_q[i]);

      done_cnt_d = done_cnt_q;
      for (int i = 0; i < NUM_CH; i++)
         if (done_v[i]) done_cnt_d = done_cnt_d + 32'd1;

      drained = (|busy_q) & ~(|busy_d) & (flush_q | (fifo_empty & ~push_req));
      ovf     = push_req & fifo_full & ~dispatch & ~flush_q;

      ap_valid_d  = hsel & htrans[1] & hready;
      ap_write_d  = hwrite;
      ap_addr_d   = haddr[7:0];
      trig_prev_d = trigger_in;
      irq_d       = irq_en_q & (|irq_stat_q);
      en_d        = en_q;
      flush_d     = 1'b0;
      irq_en_d    = irq_en_q;
      trig_en_d   = trig_en_q;
      stage_d     = stage_q;
      timeout_d   = timeout_q;
      irq_clr     = '0;
      if (wr_act) begin
         case (ap_addr_q)
            REG_CTRL: begin
               en_d      = hwdata[CTRL_EN];
               flush_d   = hwdata[CTRL_FLUSH];
               irq_en_d  = hwdata[CTRL_IRQ_EN];
               trig_en_d = hwdata[CTRL_TRIG_EN];
            end
            REG_DIM_M:   stage_d.m        = hwdata[DESC_DIM_W-1:0];
            REG_DIM_N:   stage_d.n        = hwdata[DESC_DIM_W-1:0];
            REG_DIM_K:   stage_d.k        = hwdata[DESC_DIM_W-1:0];
            REG_IN:      stage_d.in_addr  = hwdata[DESC_ADDR_W-1:0];
            REG_W:       stage_d.w_addr   = hwdata[DESC_ADDR_W-1:0];
            REG_OUT:     stage_d.out_addr = hwdata[DESC_ADDR_W-1:0];
            REG_IRQ:     irq_clr          = hwdata[3:0];
            REG_TIMEOUT: timeout_d        = hwdata[TO_W-1:0];
            default: ;
         endcase
      end
      irq_stat_d = irq_stat_q & ~irq_clr;
      irq_stat_d[IRQ_DONE]    = irq_stat_d[IRQ_DONE] | (|done_v);
      irq_stat_d[IRQ_DRAINED] = irq_stat_d[IRQ_DRAINED] | drained;
      irq_stat_d[IRQ_OVF]     = irq_stat_d[IRQ_OVF] | ovf;
      irq_stat_d[IRQ_TIMEOUT] = irq_stat_d[IRQ_TIMEOUT] | (|to_hit);

      hrdata = '0;
      if (rd_act) begin
         case (ap_addr_q)
            REG_CTRL:     hrdata = {28'd0, trig_en_q, irq_en_q, flush_q, en_q};
            REG_STATUS: begin
               hrdata[NUM_CH-1:0] = busy_q;
               hrdata[15:8]       = 8'(fifo_count);
               hrdata[16]         = fifo_full;
               hrdata[17]         = fifo_empty;
            end
            REG_DIM_M:    hrdata = 32'(stage_q.m);
            REG_DIM_N:    hrdata = 32'(stage_q.n);
            REG_DIM_K:    hrdata = 32'(stage_q.k);
            REG_IN:       hrdata = 32'(stage_q.in_addr);
            REG_W:        hrdata = 32'(stage_q.w_addr);
            REG_OUT:      hrdata = 32'(stage_q.out_addr);
            REG_IRQ:      hrdata = 32'(irq_stat_q);
            REG_DONE_CNT: hrdata = done_cnt_q;
            REG_TIMEOUT:  hrdata = 32'(timeout_q);
            default:      hrdata = '0;
         endcase
      end
   end

   assign ch_start = start;
   assign ch_abort = flush_q ? busy_q : to_hit;
   assign job_m    = job_desc.m;
   assign job_n    = job_desc.n;
   assign job_k    = job_desc.k;
   assign job_in   = job_desc.in_addr;
   assign job_w    = job_desc.w_addr;
   assign job_out  = job_desc.out_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         ap_valid_q  <= 1'b0;
         ap_write_q  <= 1'b0;
         ap_addr_q   <= '0;
         en_q        <= 1'b0;
         flush_q     <= 1'b0;
         irq_en_q    <= 1'b0;
         trig_en_q   <= 1'b0;
         trig_prev_q <= 1'b0;
         irq_q       <= 1'b0;
         stage_q     <= '0;
         irq_stat_q  <= '0;
         done_cnt_q  <= '0;
         timeout_q   <= '0;
         busy_q      <= '0;
         wd_cnt_q    <= '0;
         last_q      <= CH_W'(NUM_CH - 1);
      end else begin
         ap_valid_q  <= ap_valid_d;
         ap_write_q  <= ap_write_d;
         ap_addr_q   <= ap_addr_d;
         en_q        <= en_d;
         flush_q     <= flush_d;
         irq_en_q    <= irq_en_d;
         trig_en_q   <= trig_en_d;
         trig_prev_q <= trig_prev_d;
         irq_q       <= irq_d;
         stage_q     <= stage_d;
         irq_stat_q  <= irq_stat_d;
         done_cnt_q  <= done_cnt_d;
         timeout_q   <= timeout_d;
         busy_q      <= busy_d;
         wd_cnt_q    <= wd_cnt_d;
         last_q      <= last_d;
      end
   end

endmodule

// File: tb/tb_cim_job_scheduler.sv
// Bench for cim_job_scheduler: register table, directed multi-cycle scenarios and a
// randomized run against a queue-based scheduling model.
module tb_cim_job_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] haddr = '0, hwdata = '0, hrdata;
   logic        hwrite = 1'b0, hsel = 1'b0;
   logic [1:0]  htrans = '0;
   logic [2:0]  hsize = 3'd2;
   logic        hready, hresp, irq;
   logic [15:0] job_m, job_n, job_k;
   logic [31:0] job_in, job_w, job_out;
   logic [3:0]  ch_start, ch_abort;
   logic [3:0]  ch_done = '0;
   logic        trigger_in = 1'b0;

   int n_tests = 0, n_fail = 0, cyc = 0;
   logic [3:0] slog[$], alog[$];
   int         scyc[$], acyc[$];

   cim_job_scheduler dut (
      .clk(clk), .rst(rst), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata),
      .hwrite(hwrite), .hsel(hsel), .htrans(htrans), .hsize(hsize),
      .hready(hready), .hresp(hresp), .job_m(job_m), .job_n(job_n), .job_k(job_k),
      .job_in(job_in), .job_w(job_w), .job_out(job_out), .ch_start(ch_start),
      .ch_done(ch_done), .ch_abort(ch_abort), .trigger_in(trigger_in), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (ch_start != 0) begin slog.push_back(ch_start); scyc.push_back(cyc); end
      if (ch_abort != 0) begin alog.push_back(ch_abort); acyc.push_back(cyc); end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
      $fatal(1, "time limit");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = {24'd0, a};
      tick();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
      tick();
   endtask

   task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = {24'd0, a};
      tick();
      hsel = 1'b0; htrans = 2'b00;
      @(negedge clk);
      d = hrdata;
      tick();
   endtask

   task automatic apply_reset();
      rst = 1'b1; hsel = 1'b0; htrans = '0; hwrite = 1'b0; ch_done = '0; trigger_in = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      slog.delete(); scyc.delete(); alog.delete(); acyc.delete();
   endtask

   task automatic stage_and_push(input logic [15:0] m, input logic [15:0] k);
      ahb_write(8'h08, 32'(m));
      ahb_write(8'h0C, 32'd4);
      ahb_write(8'h10, 32'(k));
      ahb_write(8'h20, 32'd0);
   endtask

   // Scheduling model: job queue, per-channel busy flag and age counter.
   localparam int TO_RND = 12;
   logic [15:0] mq[$];
   logic [3:0]  mbusy;
   int          mcnt[4];
   int          mlast;
   logic [15:0] mstag;
   int unsigned mdone;
   bit          mtrig_prev;

   task automatic model_step(input logic [3:0] done, input bit trig, input bit wpush,
                             input bit wdim, input logic [15:0] wd,
                             output logic [3:0] e_start, output logic [3:0] e_abort,
                             output logic [15:0] e_m);
      logic [3:0] dv, free, old_busy;
      int g, idx;
      bit push;
      dv = done & mbusy; e_start = '0; e_abort = '0; e_m = '0; old_busy = mbusy;
      for (int i = 0; i < 4; i++)
         if (mbusy[i] && !done[i] && mcnt[i] == TO_RND) e_abort[i] = 1'b1;
      free = ~mbusy | dv;
      g = -1;
      if (mq.size() > 0)
         for (int k = 1; k <= 4; k++) begin
            idx = (mlast + k) % 4;
            if (g < 0 && free[idx]) g = idx;
         end
      push = wpush || (trig && !mtrig_prev);
      if (g >= 0) begin
         e_start[g] = 1'b1; e_m = mq.pop_front(); mlast = g;
      end
      if (push && mq.size() < 8) mq.push_back(mstag);
      for (int i = 0; i < 4; i++) if (dv[i]) mdone++;
      mbusy = (mbusy & ~dv & ~e_abort) | e_start;
      for (int i = 0; i < 4; i++)
         if (e_start[i]) mcnt[i] = 1;
         else if (old_busy[i]) mcnt[i]++;
      mtrig_prev = trig;
      if (wdim) mstag = wd;
   endtask

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;
   vec_t vt[16];

   initial begin
      logic [31:0] d;
      logic [3:0]  dn, es, ea;
      logic [15:0] em;
      bit          pend, pend_push, wpush, wdim;

      vt[0]  = '{1'b0, 8'h00, 32'h0, 32'h0};
      vt[1]  = '{1'b0, 8'h04, 32'h0, 32'h0002_0000};
      vt[2]  = '{1'b0, 8'h08, 32'h0, 32'h0};
      vt[3]  = '{1'b1, 8'h08, 32'h0000_1234, 32'h0};
      vt[4]  = '{1'b0, 8'h08, 32'h0, 32'h0000_1234};
      vt[5]  = '{1'b1, 8'h0C, 32'hFFFF_ABCD, 32'h0};
      vt[6]  = '{1'b0, 8'h0C, 32'h0, 32'h0000_ABCD};
      vt[7]  = '{1'b1, 8'h14, 32'hDEAD_BEEF, 32'h0};
      vt[8]  = '{1'b0, 8'h14, 32'h0, 32'hDEAD_BEEF};
      vt[9]  = '{1'b1, 8'h2C, 32'hFF12_3456, 32'h0};
      vt[10] = '{1'b0, 8'h2C, 32'h0, 32'h0012_3456};
      vt[11] = '{1'b1, 8'h30, 32'h5555_5555, 32'h0};
      vt[12] = '{1'b0, 8'h30, 32'h0, 32'h0};
      vt[13] = '{1'b1, 8'h00, 32'h0000_000D, 32'h0};
      vt[14] = '{1'b0, 8'h00, 32'h0, 32'h0000_000D};
      vt[15] = '{1'b0, 8'h28, 32'h0, 32'h0};

      repeat (3) tick();
      @(negedge clk);
      chk("rst_ch_start", 32'(ch_start), 0);
      chk("rst_ch_abort", 32'(ch_abort), 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_hrdata", hrdata, 0);
      chk("rst_hready_hresp", {30'd0, hready, hresp}, 32'h2);
      chk("rst_job_m", 32'(job_m), 0);
      apply_reset();

      for (int i = 0; i < 16; i++) begin
         if (vt[i].wr) ahb_write(vt[i].addr, vt[i].data);
         else begin
            ahb_read(vt[i].addr, d);
            chk($sformatf("tbl%0d_addr%h", i, vt[i].addr), d, vt[i].exp);
         end
      end

      // Single job end to end
      apply_reset();
      ahb_write(8'h00, 32'h5);
      stage_and_push(16'd4, 16'd8);
      @(negedge clk);
      chk("t1_start", 32'(ch_start), 32'h1);
      chk("t1_job_m", 32'(job_m), 32'd4);
      chk("t1_job_k", 32'(job_k), 32'd8);
      tick();
      ch_done = 4'b0001;
      tick();
      ch_done = '0;
      ahb_read(8'h28, d); chk("t1_done_cnt", d, 32'd1);
      ahb_read(8'h24, d); chk("t1_irq_stat", d, 32'h3);
      ahb_read(8'h04, d); chk("t1_status", d, 32'h0002_0000);
      chk("t1_irq", 32'(irq), 32'd1);

      // Round-robin over four channels
      apply_reset();
      ahb_write(8'h00, 32'h1);
      for (int j = 0; j < 6; j++) stage_and_push(16'(j + 1), 16'd2);
      tick();
      chk("t2_nstarts", slog.size(), 4);
      for (int j = 0; j < 4; j++)
         chk($sformatf("t2_start%0d", j), (j < slog.size()) ? 32'(slog[j]) : 32'hX, 32'(4'b1 << j));
      ahb_read(8'h04, d); chk("t2_status", d, 32'h0000_020F);

      // Overflow with dispatch halted
      apply_reset();
      for (int j = 0; j < 9; j++) ahb_write(8'h20, 32'd0);
      ahb_read(8'h04, d); chk("t3_status_full", d, 32'h0001_0800);
      ahb_read(8'h24, d); chk("t3_ovf", d, 32'h4);
      ahb_write(8'h24, 32'h4);
      ahb_read(8'h24, d); chk("t3_ovf_clr", d, 32'h0);
      ahb_read(8'h28, d); chk("t3_done_cnt", d, 32'h0);

      // Watchdog
      apply_reset();
      ahb_write(8'h2C, 32'd10);
      ahb_write(8'h00, 32'h1);
      stage_and_push(16'd3, 16'd3);
      repeat (14) tick();
      chk("t4_naborts", alog.size(), 1);
      chk("t4_abort_ch", (alog.size() > 0) ? 32'(alog[0]) : 32'hX, 32'h1);
      chk("t4_abort_delay", (alog.size() > 0 && scyc.size() > 0) ? 32'(acyc[0] - scyc[0]) : 32'hX, 32'd10);
      ahb_read(8'h24, d); chk("t4_irq_stat", d, 32'hA);
      ahb_read(8'h28, d); chk("t4_done_cnt", d, 32'h0);

      // Flush with queued and running jobs
      apply_reset();
      ahb_write(8'h00, 32'h1);
      ahb_write(8'h20, 32'd0);
      ahb_write(8'h20, 32'd0);
      ahb_write(8'h00, 32'h0);
      for (int j = 0; j < 3; j++) ahb_write(8'h20, 32'd0);
      ahb_read(8'h04, d); chk("t5_pre_status", d, 32'h0000_0303);
      slog.delete(); scyc.delete();
      ahb_write(8'h00, 32'h3);
      @(negedge clk);
      chk("t5_abort", 32'(ch_abort), 32'h3);
      chk("t5_no_start", 32'(ch_start), 32'h0);
      tick();
      ahb_read(8'h04, d); chk("t5_status", d, 32'h0002_0000);
      chk("t5_no_start_after", slog.size(), 0);

      // Trigger and PUSH coinciding, then reset mid-job
      apply_reset();
      ahb_write(8'h00, 32'h8);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20;
      tick();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; trigger_in = 1'b1;
      tick();
      trigger_in = 1'b0;
      ahb_read(8'h04, d); chk("t6_one_entry", d, 32'h0000_0100);
      trigger_in = 1'b1; tick(); trigger_in = 1'b0; tick();
      ahb_read(8'h04, d); chk("t6_trig_only", d, 32'h0000_0200);
      ahb_write(8'h00, 32'h9);
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("t6_rst_outputs", {ch_start, ch_abort, 7'd0, irq, job_m}, 32'h0);
      chk("t6_rst_hrdata", hrdata, 32'h0);
      tick();
      rst = 1'b0;
      ahb_read(8'h04, d); chk("t6_rst_status", d, 32'h0002_0000);

      // Randomized run against the model
      apply_reset();
      ahb_write(8'h2C, 32'(TO_RND));
      ahb_write(8'h00, 32'h9);
      mq.delete(); mbusy = '0; mlast = 3; mstag = '0; mdone = 0; mtrig_prev = 1'b0;
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
      pend = 1'b0; pend_push = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         dn = '0;
         for (int i = 0; i < 4; i++) if ($urandom % 6 == 0) dn[i] = 1'b1;
         ch_done = dn;
         if ($urandom % 4 == 0) trigger_in = ~trigger_in;
         wpush = 1'b0; wdim = 1'b0;
         if (pend) begin
            hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = $urandom;
            wpush = pend_push; wdim = !pend_push; pend = 1'b0;
         end else if ($urandom % 3 == 0) begin
            pend_push = ($urandom % 2) == 1;
            hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
            haddr = pend_push ? 32'h20 : 32'h08;
            pend = 1'b1;
         end else begin
            hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
         end
         @(negedge clk);
         model_step(dn, trigger_in, wpush, wdim, hwdata[15:0], es, ea, em);
         chk($sformatf("rnd%0d_start_abort", c), {24'd0, ch_start, ch_abort}, {24'd0, es, ea});
         if (es != 0) chk($sformatf("rnd%0d_job_m", c), 32'(job_m), 32'(em));
         tick();
      end
      ch_done = '0; trigger_in = 1'b0;
      if (pend) begin hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; tick(); end
      ahb_read(8'h28, d); chk("rnd_done_cnt", d, mdone);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
